// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the inter-stage pipeline registers: occupancy state
// encoding, the EX->MEM (regM) payload layout and its bubble value.
package pipe_stage_reg_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_e;

    localparam logic [3:0] MEM_NO_RW        = 4'd0;
    localparam logic       REG_WEN_NO_W     = 1'b0;
    localparam logic [1:0] WB_VALD_SEL_VALE = 2'd0;

    // regM field offsets, LSB upwards; valE sits at bit 0.
    localparam int REGM_VALE_LSB        = 0;
    localparam int REGM_VALB_LSB        = 32;
    localparam int REGM_MEM_RW_LSB      = 64;
    localparam int REGM_WB_REG_WEN_LSB  = 68;
    localparam int REGM_WB_RD_LSB       = 69;
    localparam int REGM_WB_CSR_RD_LSB   = 74;
    localparam int REGM_WB_CSR_SEL_LSB  = 86;
    localparam int REGM_WB_VALD_SEL_LSB = 89;
    localparam int REGM_INSTR_LSB       = 91;
    localparam int REGM_PC_LSB          = 123;
    localparam int REGM_PRE_PC_LSB      = 155;
    localparam int REGM_COMMIT_LSB      = 187;
    localparam int REGM_W               = 188;

    typedef struct packed {
        logic        commit;
        logic [31:0] pre_pc;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [1:0]  wb_vald_sel;
        logic [2:0]  wb_csr_sel;
        logic [11:0] wb_csr_rd;
        logic [4:0]  wb_rd;
        logic        wb_reg_wen;
        logic [3:0]  mem_rw;
        logic [31:0] valb;
        logic [31:0] vale;
    } regm_t;

    localparam regm_t REGM_BUBBLE = '{
        commit:      1'b0,
        pre_pc:      32'd0,
        pc:          32'd0,
        instr:       32'd0,
        wb_vald_sel: WB_VALD_SEL_VALE,
        wb_csr_sel:  3'd0,
        wb_csr_rd:   12'd0,
        wb_rd:       5'd0,
        wb_reg_wen:  REG_WEN_NO_W,
        mem_rw:      MEM_NO_RW,
        valb:        32'd0,
        vale:        32'd0
    };

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready channel carrying one packed stage payload; the master drives
// valid and payload, the slave answers with ready.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 96
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] payload;

    modport master (output valid, output payload, input ready);
    modport slave  (input valid, input payload, output ready);
endinterface

// File: rtl/pipe_stage_reg_sat_ctr.sv
// Saturating performance counter that adds 0..3 per cycle and can be cleared.
module pipe_sat_ctr #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [1:0]       inc,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W:0] sum;

    assign sum = {1'b0, count} + {{(CNT_W-1){1'b0}}, inc};

    // The carry bit means the add went past all-ones, so pin at the ceiling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (sum[CNT_W]) begin
            count <= '1;
        end else begin
            count <= sum[CNT_W-1:0];
        end
    end
endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready handshake, optional
// two-entry skid buffer, flush-to-bubble and stall/drop perf counters.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int              DATA_W  = 96,
    parameter bit              SKID_EN = 1'b1,
    parameter logic [DATA_W-1:0] BUBBLE = {DATA_W{1'b0}},
    parameter int              CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               cnt_clr,
    pipe_stage_reg_if.slave    in_ch,
    pipe_stage_reg_if.master   out_ch,
    output logic [1:0]         occupancy,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   drop_cnt
);
    pipe_state_e       state;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              in_ready;
    logic              out_valid;
    logic              in_fire;
    logic              out_fire;
    logic [1:0]        stall_inc;
    logic [1:0]        drop_inc;

    assign out_valid = (state != ST_EMPTY);

    // With the skid buffer in_ready comes straight from the state flops,
    // cutting the ready path from downstream.
    always_comb begin
        in_ready = 1'b0;
        if (SKID_EN) begin
            in_ready = (state != ST_TWO);
        end else begin
            in_ready = !out_valid | out_ch.ready;
        end
    end

    assign in_fire        = in_ch.valid & in_ready;
    assign out_fire       = out_valid & out_ch.ready;
    assign in_ch.ready    = in_ready;
    assign out_ch.valid   = out_valid;
    assign out_ch.payload = main_q;
    assign occupancy      = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_EMPTY;
            main_q <= BUBBLE;
            skid_q <= BUBBLE;
        end else if (flush) begin
            state  <= ST_EMPTY;
            main_q <= BUBBLE;
            skid_q <= BUBBLE;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state  <= ST_ONE;
                        main_q <= in_ch.payload;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_ch.payload;
                    end else if (in_fire) begin
                        if (SKID_EN) begin
                            state  <= ST_TWO;
                            skid_q <= in_ch.payload;
                        end
                    end else if (out_fire) begin
                        state  <= ST_EMPTY;
                        main_q <= BUBBLE;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        state  <= ST_ONE;
                        main_q <= skid_q;
                        skid_q <= BUBBLE;
                    end
                end
                default: begin
                    state  <= ST_EMPTY;
                    main_q <= BUBBLE;
                    skid_q <= BUBBLE;
                end
            endcase
        end
    end

    // A head entry leaving in the flush cycle completed, so it is not a drop.
    assign drop_inc  = flush ? (occupancy + {1'b0, in_fire} - {1'b0, out_fire}) : 2'd0;
    assign stall_inc = {1'b0, out_valid & ~out_ch.ready};

    pipe_sat_ctr #(.CNT_W(CNT_W)) u_stall_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    pipe_sat_ctr #(.CNT_W(CNT_W)) u_drop_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (drop_inc),
        .count (drop_cnt)
    );
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid instance (4-bit counters, non-zero bubble)
// and a no-skid instance share stimulus and are checked against a queue model.
module tb_pipe_stage_reg;

    localparam logic [31:0] BUB_S = 32'hB0B0_0000;
    localparam logic [31:0] BUB_N = 32'h0000_0000;
    localparam int MAX_S = 15;
    localparam int MAX_N = 65535;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        cnt_clr;
    logic        in_valid;
    logic [31:0] in_payload;
    logic        out_ready;

    logic [1:0]  occ_s, occ_n;
    logic [3:0]  stall_s, drop_s;
    logic [15:0] stall_n, drop_n;

    pipe_stage_reg_if #(.DATA_W(32)) up_s ();
    pipe_stage_reg_if #(.DATA_W(32)) dn_s ();
    pipe_stage_reg_if #(.DATA_W(32)) up_n ();
    pipe_stage_reg_if #(.DATA_W(32)) dn_n ();

    assign up_s.valid   = in_valid;
    assign up_s.payload = in_payload;
    assign dn_s.ready   = out_ready;
    assign up_n.valid   = in_valid;
    assign up_n.payload = in_payload;
    assign dn_n.ready   = out_ready;

    pipe_stage_reg #(.DATA_W(32), .SKID_EN(1'b1), .BUBBLE(BUB_S), .CNT_W(4)) dut_s (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .cnt_clr   (cnt_clr),
        .in_ch     (up_s),
        .out_ch    (dn_s),
        .occupancy (occ_s),
        .stall_cnt (stall_s),
        .drop_cnt  (drop_s)
    );

    pipe_stage_reg #(.DATA_W(32), .SKID_EN(1'b0), .BUBBLE(BUB_N), .CNT_W(16)) dut_n (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .cnt_clr   (cnt_clr),
        .in_ch     (up_n),
        .out_ch    (dn_n),
        .occupancy (occ_n),
        .stall_cnt (stall_n),
        .drop_cnt  (drop_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;

    // Reference model: each stage is just a bounded FIFO plus two counters.
    logic [31:0] m_qs[$];
    logic [31:0] m_qn[$];
    int m_stall_s, m_drop_s, m_stall_n, m_drop_n;

    typedef struct {
        logic        iv;
        logic [31:0] p;
        logic        ordy;
        logic        fl;
        logic        e_ov;
        logic [31:0] e_pay;
        logic        e_ir;
        logic [1:0]  e_occ;
        int          e_stall;
        int          e_drop;
    } vec_t;

    vec_t tbl[$];
    logic [31:0] got_n[$];
    int max_occ_n;

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic vec_t mk(input logic iv, input logic [31:0] p, input logic ordy,
                                input logic fl, input logic e_ov, input logic [31:0] e_pay,
                                input logic e_ir, input logic [1:0] e_occ,
                                input int e_stall, input int e_drop);
        vec_t v;
        v.iv = iv; v.p = p; v.ordy = ordy; v.fl = fl;
        v.e_ov = e_ov; v.e_pay = e_pay; v.e_ir = e_ir; v.e_occ = e_occ;
        v.e_stall = e_stall; v.e_drop = e_drop;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic [31:0] p, input logic ordy,
                                 input logic fl, input logic clr);
        @(negedge clk);
        in_valid   = iv;
        in_payload = p;
        out_ready  = ordy;
        flush      = fl;
        cnt_clr    = clr;
        #1;
    endtask

    task automatic modelReset();
        m_qs.delete();
        m_qn.delete();
        m_stall_s = 0; m_drop_s = 0; m_stall_n = 0; m_drop_n = 0;
    endtask

    task automatic checkModel();
        logic [31:0] ep;
        ep = (m_qs.size() > 0) ? m_qs[0] : BUB_S;
        checkOutput("s_out_valid", 64'(dn_s.valid), (m_qs.size() > 0) ? 64'd1 : 64'd0);
        checkOutput("s_out_payload", 64'(dn_s.payload), 64'(ep));
        checkOutput("s_in_ready", 64'(up_s.ready), (m_qs.size() < 2) ? 64'd1 : 64'd0);
        checkOutput("s_occupancy", 64'(occ_s), 64'(m_qs.size()));
        checkOutput("s_stall_cnt", 64'(stall_s), 64'(m_stall_s));
        checkOutput("s_drop_cnt", 64'(drop_s), 64'(m_drop_s));
        ep = (m_qn.size() > 0) ? m_qn[0] : BUB_N;
        checkOutput("n_out_valid", 64'(dn_n.valid), (m_qn.size() > 0) ? 64'd1 : 64'd0);
        checkOutput("n_out_payload", 64'(dn_n.payload), 64'(ep));
        checkOutput("n_in_ready", 64'(up_n.ready),
                    ((m_qn.size() == 0) || out_ready) ? 64'd1 : 64'd0);
        checkOutput("n_occupancy", 64'(occ_n), 64'(m_qn.size()));
        checkOutput("n_stall_cnt", 64'(stall_n), 64'(m_stall_n));
        checkOutput("n_drop_cnt", 64'(drop_n), 64'(m_drop_n));
    endtask

    // Advance both models by one clock using the inputs currently driven.
    task automatic modelStep();
        bit ov, inf, outf;
        ov   = (m_qs.size() > 0);
        inf  = in_valid && (m_qs.size() < 2);
        outf = ov && out_ready;
        if (cnt_clr) begin
            m_stall_s = 0; m_drop_s = 0;
        end else begin
            if (ov && !out_ready) m_stall_s = sat(m_stall_s + 1, MAX_S);
            if (flush) m_drop_s = sat(m_drop_s + m_qs.size() - int'(outf) + int'(inf), MAX_S);
        end
        if (flush) m_qs.delete();
        else begin
            if (outf) void'(m_qs.pop_front());
            if (inf) m_qs.push_back(in_payload);
        end

        ov   = (m_qn.size() > 0);
        inf  = in_valid && ((m_qn.size() == 0) || out_ready);
        outf = ov && out_ready;
        if (cnt_clr) begin
            m_stall_n = 0; m_drop_n = 0;
        end else begin
            if (ov && !out_ready) m_stall_n = sat(m_stall_n + 1, MAX_N);
            if (flush) m_drop_n = sat(m_drop_n + m_qn.size() - int'(outf) + int'(inf), MAX_N);
        end
        if (flush) m_qn.delete();
        else begin
            if (outf) void'(m_qn.pop_front());
            if (inf) m_qn.push_back(in_payload);
        end
    endtask

    task automatic cycle(input logic iv, input logic [31:0] p, input logic ordy,
                         input logic fl, input logic clr);
        applyStimulus(iv, p, ordy, fl, clr);
        checkModel();
        modelStep();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        in_valid = 1'b0; in_payload = '0; out_ready = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
        modelReset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Streaming, back-pressure, flush and flush-with-transfer on the skid stage.
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(1'b1, 32'(i + 1), 1'b1, 1'b0, i > 0, (i > 0) ? 32'(i) : BUB_S,
                             1'b1, (i > 0) ? 2'd1 : 2'd0, 0, 0));
        tbl.push_back(mk(0, 0,     1, 0, 1, 32'h8, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0,     1, 0, 0, BUB_S, 1, 0, 0, 0));
        tbl.push_back(mk(1, 32'hA, 0, 0, 0, BUB_S, 1, 0, 0, 0));
        tbl.push_back(mk(1, 32'hB, 0, 0, 1, 32'hA, 1, 1, 0, 0));
        tbl.push_back(mk(1, 32'hC, 0, 0, 1, 32'hA, 0, 2, 1, 0));
        tbl.push_back(mk(1, 32'hC, 0, 0, 1, 32'hA, 0, 2, 2, 0));
        tbl.push_back(mk(1, 32'hC, 0, 0, 1, 32'hA, 0, 2, 3, 0));
        tbl.push_back(mk(1, 32'hC, 1, 0, 1, 32'hA, 0, 2, 4, 0));
        tbl.push_back(mk(1, 32'hC, 1, 0, 1, 32'hB, 1, 1, 4, 0));
        tbl.push_back(mk(0, 0,     1, 0, 1, 32'hC, 1, 1, 4, 0));
        tbl.push_back(mk(0, 0,     1, 0, 0, BUB_S, 1, 0, 4, 0));
        tbl.push_back(mk(1, 32'hA, 0, 0, 0, BUB_S, 1, 0, 4, 0));
        tbl.push_back(mk(1, 32'hB, 0, 0, 1, 32'hA, 1, 1, 4, 0));
        tbl.push_back(mk(1, 32'hC, 0, 1, 1, 32'hA, 0, 2, 5, 0));
        tbl.push_back(mk(0, 0,     1, 0, 0, BUB_S, 1, 0, 6, 2));
        tbl.push_back(mk(1, 32'hA, 0, 0, 0, BUB_S, 1, 0, 6, 2));
        tbl.push_back(mk(0, 0,     1, 1, 1, 32'hA, 1, 1, 6, 2));
        tbl.push_back(mk(0, 0,     1, 0, 0, BUB_S, 1, 0, 6, 2));
        tbl.push_back(mk(1, 32'hA, 0, 0, 0, BUB_S, 1, 0, 6, 2));
        tbl.push_back(mk(1, 32'hB, 1, 1, 1, 32'hA, 1, 1, 6, 2));
        tbl.push_back(mk(0, 0,     1, 0, 0, BUB_S, 1, 0, 6, 3));

        foreach (tbl[i]) begin
            applyStimulus(tbl[i].iv, tbl[i].p, tbl[i].ordy, tbl[i].fl, 1'b0);
            checkModel();
            checkOutput($sformatf("tbl%0d_out_valid", i), 64'(dn_s.valid), 64'(tbl[i].e_ov));
            checkOutput($sformatf("tbl%0d_payload", i), 64'(dn_s.payload), 64'(tbl[i].e_pay));
            checkOutput($sformatf("tbl%0d_in_ready", i), 64'(up_s.ready), 64'(tbl[i].e_ir));
            checkOutput($sformatf("tbl%0d_occ", i), 64'(occ_s), 64'(tbl[i].e_occ));
            checkOutput($sformatf("tbl%0d_stall", i), 64'(stall_s), 64'(tbl[i].e_stall));
            checkOutput($sformatf("tbl%0d_drop", i), 64'(drop_s), 64'(tbl[i].e_drop));
            modelStep();
        end

        // Saturation of the 4-bit stall counter, then clear during a stall.
        cycle(0, 0, 1, 0, 1);
        cycle(1, 32'h55, 0, 0, 0);
        repeat (20) cycle(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1);
        checkModel();
        checkOutput("sat_stall_cnt", 64'(stall_s), 64'd15);
        modelStep();
        applyStimulus(0, 0, 0, 0, 0);
        checkModel();
        checkOutput("clr_stall_cnt", 64'(stall_s), 64'd0);
        modelStep();
        repeat (2) cycle(0, 0, 1, 0, 0);

        // No-skid streaming of 0x10..0x18: order and single-entry occupancy.
        max_occ_n = 0;
        got_n.delete();
        for (int i = 0; i < 12; i++) begin
            applyStimulus(i < 9, (i < 9) ? 32'(32'h10 + i) : 32'h0, 1'b1, 1'b0, 1'b0);
            checkModel();
            if (dn_n.valid && out_ready) got_n.push_back(dn_n.payload);
            if (int'(occ_n) > max_occ_n) max_occ_n = int'(occ_n);
            modelStep();
        end
        checkOutput("n_stream_count", 64'(got_n.size()), 64'd9);
        for (int i = 0; i < 9; i++) begin
            if (i < got_n.size())
                checkOutput($sformatf("n_stream_%0d", i), 64'(got_n[i]), 64'(32'h10 + i));
        end
        checkOutput("n_occ_le_1", (max_occ_n <= 1) ? 64'd1 : 64'd0, 64'd1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0);
        end

        // Asynchronous reset while the skid stage holds two entries.
        cycle(0, 0, 1, 1, 0);
        cycle(1, 32'hA, 0, 0, 0);
        cycle(1, 32'hB, 0, 0, 0);
        cycle(1, 32'hC, 0, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        checkOutput("pre_reset_occ", 64'(occ_s), 64'd2);
        #3;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkModel();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(0, 0, 1, 0, 0);
        cycle(1, 32'h77, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
